// File: rtl/grom_io_pkg.sv
// Shared constants and helpers for the grom I/O port peripheral.
package grom_io_pkg;

  localparam int IO_DW = 8;

  localparam logic [7:0] IO_PORT_BASE = 8'h00;
  localparam logic [7:0] IO_IN_LEVEL  = 8'h10;
  localparam logic [7:0] IO_IN_EDGE   = 8'h11;
  localparam logic [7:0] IO_ID        = 8'h12;

  // Which register an I/O address selects, resolved once by the decoder.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PORT,
    SEL_LEVEL,
    SEL_EDGE,
    SEL_ID
  } io_sel_e;

  // Identification byte: output port count in the high nibble, input count low.
  function automatic logic [7:0] io_id(input logic [3:0] n_out, input logic [3:0] n_in);
    return {n_out, n_in};
  endfunction

endpackage

// File: rtl/grom_debounce.sv
// Two-flop synchroniser plus stability counter for one raw button input.
module grom_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Raw,
  output logic o_Stable,
  output logic o_Rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; accept the new level at the terminal count.
  always_comb begin
    sync1_d  = i_Raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, accepted level and counter registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_Stable = stable_q;
  assign o_Rise   = stable_d & ~stable_q;

endmodule

// File: rtl/grom_io_port.sv
// Bank of read/write output ports plus debounced buttons with sticky rise flags.
module grom_io_port
  import grom_io_pkg::*;
#(
  parameter int NUM_OUT         = 4,
  parameter int NUM_IN          = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_n,
  input  logic [11:0]              i_Addr,
  input  logic [IO_DW-1:0]         i_Data,
  input  logic                     i_We,
  input  logic                     i_Ioreq,
  output logic [IO_DW-1:0]         o_Rd_Data,
  input  logic [NUM_IN-1:0]        i_Buttons,
  output logic [NUM_OUT*IO_DW-1:0] o_Ports,
  output logic [NUM_OUT-1:0]       o_Wr_Strobe
);

  logic [NUM_OUT-1:0][IO_DW-1:0] ports_q, ports_d;
  logic [NUM_OUT-1:0]            wr_strobe_q, wr_strobe_d;
  logic [IO_DW-1:0]              rd_data_q, rd_data_d;
  logic [NUM_IN-1:0]             edge_flags_q, edge_flags_d;

  logic [NUM_IN-1:0]  in_level;
  logic [NUM_IN-1:0]  in_rise;
  logic [7:0]         port_addr;
  logic [NUM_OUT-1:0] port_hit;
  logic               wr_en;
  logic               rd_en;
  io_sel_e            sel;
  logic               unused_addr_hi;

  assign port_addr      = i_Addr[7:0];
  assign unused_addr_hi = ^i_Addr[11:8];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    grom_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .i_Raw   (i_Buttons[i]),
      .o_Stable(in_level[i]),
      .o_Rise  (in_rise[i])
    );
  end

  // Decode the port number into a register select and a one-hot port match.
  always_comb begin
    wr_en    = i_Ioreq & i_We;
    rd_en    = i_Ioreq & ~i_We;
    port_hit = '0;
    sel      = SEL_NONE;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (port_addr == IO_PORT_BASE + 8'(k)) begin
        port_hit[k] = 1'b1;
        sel         = SEL_PORT;
      end
    end
    if (port_addr == IO_IN_LEVEL) sel = SEL_LEVEL;
    if (port_addr == IO_IN_EDGE)  sel = SEL_EDGE;
    if (port_addr == IO_ID)       sel = SEL_ID;
  end

  // Port bank update and the one-cycle strobe marking which port was written.
  always_comb begin
    ports_d     = ports_q;
    wr_strobe_d = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (wr_en && port_hit[k]) begin
        ports_d[k]     = i_Data;
        wr_strobe_d[k] = 1'b1;
      end
    end
  end

  // Sticky rise flags: write-one-to-clear first, then a new rise sets so it wins.
  always_comb begin
    edge_flags_d = edge_flags_q;
    if (wr_en && sel == SEL_EDGE) begin
      edge_flags_d = edge_flags_q & ~i_Data[NUM_IN-1:0];
    end
    edge_flags_d = edge_flags_d | in_rise;
  end

  // Read mux; the captured value holds until the next I/O read.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      case (sel)
        SEL_PORT: begin
          for (int k = 0; k < NUM_OUT; k++) begin
            if (port_hit[k]) rd_data_d = ports_q[k];
          end
        end
        SEL_LEVEL: rd_data_d = IO_DW'(in_level);
        SEL_EDGE:  rd_data_d = IO_DW'(edge_flags_q);
        SEL_ID:    rd_data_d = io_id(4'(NUM_OUT), 4'(NUM_IN));
        default:   rd_data_d = '0;
      endcase
    end
  end

  // All architectural registers; reset overrides any access in the same cycle.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      ports_q      <= '0;
      wr_strobe_q  <= '0;
      rd_data_q    <= '0;
      edge_flags_q <= '0;
    end else begin
      ports_q      <= ports_d;
      wr_strobe_q  <= wr_strobe_d;
      rd_data_q    <= rd_data_d;
      edge_flags_q <= edge_flags_d;
    end
  end

  assign o_Ports     = ports_q;
  assign o_Wr_Strobe = wr_strobe_q;
  assign o_Rd_Data   = rd_data_q;

endmodule

// File: tb/tb_grom_io_port.sv
// Self-checking bench for grom_io_port with a behavioural model of the register map.
module tb_grom_io_port;

  localparam int NUM_OUT = 4;
  localparam int NUM_IN  = 2;
  localparam int DEB     = 4;

  logic                   clk;
  logic                   rst_n;
  logic [11:0]            addr;
  logic [7:0]             data;
  logic                   we;
  logic                   ioreq;
  logic [NUM_IN-1:0]      buttons;
  logic [7:0]             dut_rd;
  logic [NUM_OUT*8-1:0]   dut_ports;
  logic [NUM_OUT-1:0]     dut_strobe;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: what the register map should hold after each clock edge.
  logic [7:0]        m_ports [NUM_OUT];
  logic [NUM_OUT-1:0] m_strobe;
  logic [7:0]        m_rd;
  logic [NUM_IN-1:0] m_stable;
  logic [NUM_IN-1:0] m_flags;
  logic [NUM_IN-1:0] m_dly1;
  logic [NUM_IN-1:0] m_dly2;
  int                m_run [NUM_IN];

  grom_io_port #(
    .NUM_OUT(NUM_OUT),
    .NUM_IN(NUM_IN),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Addr(addr),
    .i_Data(data),
    .i_We(we),
    .i_Ioreq(ioreq),
    .o_Rd_Data(dut_rd),
    .i_Buttons(buttons),
    .o_Ports(dut_ports),
    .o_Wr_Strobe(dut_strobe)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int ai;
    ai = int'(a);
    if (ai < NUM_OUT) return m_ports[ai];
    if (a == 8'h10) return 8'(m_stable);
    if (a == 8'h11) return 8'(m_flags);
    if (a == 8'h12) return {4'(NUM_OUT), 4'(NUM_IN)};
    return 8'h00;
  endfunction

  function automatic logic [NUM_OUT*8-1:0] model_ports();
    logic [NUM_OUT*8-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_OUT; k++) r[k*8 +: 8] = m_ports[k];
    return r;
  endfunction

  // Model update at every edge: a read sees pre-edge state; an input's level flips once its
  // two-edge-delayed value has disagreed with the level for DEB consecutive edges; a rise
  // sets its flag after any write-one-to-clear so the set wins.
  always @(posedge clk) begin
    logic [NUM_IN-1:0] rise;
    int ai;
    rise = '0;
    ai = int'(addr[7:0]);
    if (!rst_n) begin
      for (int k = 0; k < NUM_OUT; k++) m_ports[k] = 8'h00;
      m_strobe = '0;
      m_rd     = 8'h00;
      m_stable = '0;
      m_flags  = '0;
      m_dly1   = '0;
      m_dly2   = '0;
      for (int i = 0; i < NUM_IN; i++) m_run[i] = 0;
    end else begin
      if (ioreq && !we) m_rd = model_read(addr[7:0]);
      m_strobe = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (m_dly2[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_stable[i] = m_dly2[i];
            m_run[i]    = 0;
            rise[i]     = m_dly2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (ioreq && we) begin
        if (ai < NUM_OUT) begin
          m_ports[ai]  = data;
          m_strobe[ai] = 1'b1;
        end else if (addr[7:0] == 8'h11) begin
          m_flags = m_flags & ~data[NUM_IN-1:0];
        end
      end
      m_flags = m_flags | rise;
      m_dly2  = m_dly1;
      m_dly1  = buttons;
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    ioreq = 1'b0;
    we    = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    addr  = a;
    data  = d;
    we    = 1'b1;
    ioreq = 1'b1;
    cycle();
    idle();
  endtask

  task automatic rd(input logic [11:0] a);
    addr  = a;
    we    = 1'b0;
    ioreq = 1'b1;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    buttons = '0;
    addr    = 12'h000;
    data    = 8'h00;
    idle();
    cycle();
    cycle();
    n_cmp++;
    if (dut_ports !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_ports: got %h expected %h", dut_ports, 32'h0);
    end
    n_cmp++;
    if (dut_rd !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_rd: got %h expected %h", dut_rd, 8'h00);
    end
    n_cmp++;
    if (dut_strobe !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_strobe: got %b expected %b", dut_strobe, 4'b0000);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_port_write();
    wr(12'h002, 8'hA5);
    n_cmp++;
    if (dut_ports !== 32'h00A5_0000) begin
      n_fail++;
      $display("[TB] FAIL port2_write: got %h expected %h", dut_ports, 32'h00A5_0000);
    end
    n_cmp++;
    if (dut_strobe !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL port2_strobe: got %b expected %b", dut_strobe, 4'b0100);
    end
    cycle();
    n_cmp++;
    if (dut_strobe !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL strobe_one_cycle: got %b expected %b", dut_strobe, 4'b0000);
    end
    rd(12'h002);
    n_cmp++;
    if (dut_rd !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL port2_read: got %h expected %h", dut_rd, 8'hA5);
    end
  endtask

  task automatic test_debounce();
    buttons = 2'b11;
    addr    = 12'h010;
    we      = 1'b0;
    ioreq   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cycle();
      if (c == 3) buttons[1] = 1'b0;
      n_cmp++;
      if (dut_rd !== m_rd) begin
        n_fail++;
        $display("[TB] FAIL level_cycle%0d: got %h expected %h", c, dut_rd, m_rd);
      end
      if (c == 6) begin
        n_cmp++;
        if (dut_rd !== 8'h00) begin
          n_fail++;
          $display("[TB] FAIL level_too_early: got %h expected %h", dut_rd, 8'h00);
        end
      end
      if (c == 7 || c == 9) begin
        n_cmp++;
        if (dut_rd !== 8'h01) begin
          n_fail++;
          $display("[TB] FAIL level_accepted_c%0d: got %h expected %h", c, dut_rd, 8'h01);
        end
      end
    end
    idle();
    rd(12'h011);
    n_cmp++;
    if (dut_rd !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL flags_after_glitch: got %h expected %h", dut_rd, 8'h01);
    end
  endtask

  task automatic test_w1c();
    wr(12'h011, 8'h01);
    rd(12'h011);
    n_cmp++;
    if (dut_rd !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL w1c_clear: got %h expected %h", dut_rd, 8'h00);
    end
    buttons[1] = 1'b1;
    for (int c = 1; c <= 5; c++) cycle();
    wr(12'h011, 8'h02);
    rd(12'h011);
    n_cmp++;
    if (dut_rd !== 8'h02) begin
      n_fail++;
      $display("[TB] FAIL set_beats_clear: got %h expected %h", dut_rd, 8'h02);
    end
    n_cmp++;
    if (dut_rd !== m_rd) begin
      n_fail++;
      $display("[TB] FAIL set_beats_clear_model: got %h expected %h", dut_rd, m_rd);
    end
  endtask

  task automatic test_unmapped();
    wr(12'h030, 8'hFF);
    n_cmp++;
    if (dut_ports !== 32'h00A5_0000) begin
      n_fail++;
      $display("[TB] FAIL unmapped_write_ports: got %h expected %h", dut_ports, 32'h00A5_0000);
    end
    n_cmp++;
    if (dut_strobe !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL unmapped_write_strobe: got %b expected %b", dut_strobe, 4'b0000);
    end
    rd(12'h030);
    n_cmp++;
    if (dut_rd !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL unmapped_read: got %h expected %h", dut_rd, 8'h00);
    end
    rd(12'h012);
    n_cmp++;
    if (dut_rd !== 8'h42) begin
      n_fail++;
      $display("[TB] FAIL id_read: got %h expected %h", dut_rd, 8'h42);
    end
  endtask

  task automatic test_reset_mid();
    buttons = 2'b00;
    for (int c = 0; c < 10; c++) cycle();
    wr(12'h000, 8'h11);
    wr(12'h001, 8'h22);
    wr(12'h003, 8'h33);
    rd(12'h003);
    buttons[0] = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    rst_n = 1'b0;
    addr  = 12'h000;
    data  = 8'h99;
    we    = 1'b1;
    ioreq = 1'b1;
    cycle();
    rst_n = 1'b1;
    idle();
    n_cmp++;
    if (dut_ports !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_ports: got %h expected %h", dut_ports, 32'h0);
    end
    n_cmp++;
    if (dut_rd !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL midreset_rd: got %h expected %h", dut_rd, 8'h00);
    end
    n_cmp++;
    if (dut_strobe !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL midreset_strobe: got %b expected %b", dut_strobe, 4'b0000);
    end
    ioreq = 1'b1;
    addr  = 12'h011;
    for (int c = 1; c <= 7; c++) begin
      cycle();
      addr = 12'h010;
      if (c == 1) begin
        n_cmp++;
        if (dut_rd !== 8'h00) begin
          n_fail++;
          $display("[TB] FAIL midreset_flags: got %h expected %h", dut_rd, 8'h00);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (dut_rd !== 8'h00) begin
          n_fail++;
          $display("[TB] FAIL midreset_partial_kept: got %h expected %h", dut_rd, 8'h00);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (dut_rd !== 8'h01) begin
          n_fail++;
          $display("[TB] FAIL midreset_full_debounce: got %h expected %h", dut_rd, 8'h01);
        end
      end
    end
    idle();
  endtask

  task automatic test_no_ioreq();
    wr(12'h001, 8'h3C);
    rd(12'h001);
    addr  = 12'h000;
    data  = 8'h77;
    we    = 1'b1;
    ioreq = 1'b0;
    cycle();
    n_cmp++;
    if (dut_ports[7:0] !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL noioreq_port0: got %h expected %h", dut_ports[7:0], 8'h00);
    end
    n_cmp++;
    if (dut_strobe !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL noioreq_strobe: got %b expected %b", dut_strobe, 4'b0000);
    end
    n_cmp++;
    if (dut_rd !== 8'h3C) begin
      n_fail++;
      $display("[TB] FAIL noioreq_rd_hold: got %h expected %h", dut_rd, 8'h3C);
    end
    we = 1'b0;
    cycle();
    n_cmp++;
    if (dut_rd !== 8'h3C) begin
      n_fail++;
      $display("[TB] FAIL noioreq_read_hold: got %h expected %h", dut_rd, 8'h3C);
    end
    idle();
  endtask

  task automatic test_random();
    logic [7:0] addr_tab [8];
    addr_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h00};
    for (int c = 0; c < 400; c++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      addr_tab[7] = 8'($urandom);
      addr  = {4'($urandom), addr_tab[sel]};
      data  = 8'($urandom);
      we    = ($urandom_range(0, 2) == 0);
      ioreq = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        buttons[$urandom_range(0, NUM_IN - 1)] ^= 1'b1;
      end
      cycle();
      n_cmp++;
      if (dut_ports !== model_ports()) begin
        n_fail++;
        $display("[TB] FAIL rand_ports c%0d: got %h expected %h", c, dut_ports, model_ports());
      end
      n_cmp++;
      if (dut_strobe !== m_strobe) begin
        n_fail++;
        $display("[TB] FAIL rand_strobe c%0d: got %b expected %b", c, dut_strobe, m_strobe);
      end
      n_cmp++;
      if (dut_rd !== m_rd) begin
        n_fail++;
        $display("[TB] FAIL rand_rd c%0d: got %h expected %h", c, dut_rd, m_rd);
      end
    end
    idle();
  endtask

  // Scenario sequence, then the single summary line.
  initial begin
    rst_n   = 1'b0;
    buttons = '0;
    addr    = '0;
    data    = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_port_write();
    test_debounce();
    test_w1c();
    test_unmapped();
    test_reset_mid();
    test_no_ioreq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
